// File: rtl/axi4l_arbiter_if.sv
// axi4l_arbiter_if: AXI4-Lite field widths and the channel bundle shared by masters and the peripheral
package axi4l_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;
    typedef logic [2:0]  prot_t;
endpackage

interface axi4l_if;
    import axi4l_pkg::*;
    addr_t awaddr;
    prot_t awprot;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    prot_t arprot;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_arbiter.sv
// axi4l_arbiter: two-to-one AXI4-Lite arbiter with independent write and read paths
module axi4l_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input logic     aclk,
    input logic     aresetn,
    axi4l_if.slave  s0,
    axi4l_if.slave  s1,
    axi4l_if.master m
);
    localparam logic [1:0] W_IDLE = 2'd0, W_ADDR_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;

    logic [1:0] w_state, r_state;
    logic       wg, rg, w_last, r_last, aw_done, w_done;
    logic       w_req0, w_req1, r_req0, r_req1, w_win, r_win;
    logic       w_fwd, w_rsp, r_adr, r_dat, ws, rs;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign w_req0 = s0.awvalid || s0.wvalid;
    assign w_req1 = s1.awvalid || s1.wvalid;
    assign r_req0 = s0.arvalid;
    assign r_req1 = s1.arvalid;

    // On a tie the pointer hands the path to whoever was not served last
    assign w_win = (w_req0 && w_req1) ? (FAIR ? !w_last : 1'b0) : w_req1;
    assign r_win = (r_req0 && r_req1) ? (FAIR ? !r_last : 1'b0) : r_req1;

    assign w_fwd = w_state == W_ADDR_DATA;
    assign w_rsp = w_state == W_RESP;
    assign r_adr = r_state == R_ADDR;
    assign r_dat = r_state == R_DATA;

    // Payload muxes fall back to s0 whenever the path holds no grant
    assign ws = wg && w_state != W_IDLE;
    assign rs = rg && r_state != R_IDLE;

    assign m.awaddr  = ws ? s1.awaddr : s0.awaddr;
    assign m.awprot  = ws ? s1.awprot : s0.awprot;
    assign m.wdata   = ws ? s1.wdata  : s0.wdata;
    assign m.wstrb   = ws ? s1.wstrb  : s0.wstrb;
    assign m.awvalid = w_fwd && !aw_done && (ws ? s1.awvalid : s0.awvalid);
    assign m.wvalid  = w_fwd && !w_done && (ws ? s1.wvalid : s0.wvalid);
    assign m.bready  = w_rsp && (ws ? s1.bready : s0.bready);

    assign s0.awready = w_fwd && !wg && !aw_done && m.awready;
    assign s1.awready = w_fwd && wg && !aw_done && m.awready;
    assign s0.wready  = w_fwd && !wg && !w_done && m.wready;
    assign s1.wready  = w_fwd && wg && !w_done && m.wready;
    assign s0.bvalid  = w_rsp && !wg && m.bvalid;
    assign s1.bvalid  = w_rsp && wg && m.bvalid;
    assign s0.bresp   = m.bresp;
    assign s1.bresp   = m.bresp;

    assign m.araddr  = rs ? s1.araddr : s0.araddr;
    assign m.arprot  = rs ? s1.arprot : s0.arprot;
    assign m.arvalid = r_adr && (rs ? s1.arvalid : s0.arvalid);
    assign m.rready  = r_dat && (rs ? s1.rready : s0.rready);

    assign s0.arready = r_adr && !rg && m.arready;
    assign s1.arready = r_adr && rg && m.arready;
    assign s0.rvalid  = r_dat && !rg && m.rvalid;
    assign s1.rvalid  = r_dat && rg && m.rvalid;
    assign s0.rdata   = m.rdata;
    assign s1.rdata   = m.rdata;
    assign s0.rresp   = m.rresp;
    assign s1.rresp   = m.rresp;

    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid && m.wready;
    assign b_hs  = m.bvalid && m.bready;
    assign ar_hs = m.arvalid && m.arready;
    assign r_hs  = m.rvalid && m.rready;

    // Write path: grant, collect AW and W in either order, then wait for B
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            wg      <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (w_req0 || w_req1) begin
                        wg      <= w_win;
                        w_state <= W_ADDR_DATA;
                    end
                end
                W_ADDR_DATA: begin
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_hs;
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state <= W_IDLE;
                        w_last  <= wg;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: grant, forward AR, then forward R
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            rg      <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_req0 || r_req1) begin
                        rg      <= r_win;
                        r_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs)
                        r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_state <= R_IDLE;
                        r_last  <= rg;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4l_arbiter.sv
// tb_axi4l_arbiter: directed checks of grant order, channel routing, backpressure and reset
module tb_axi4l_arbiter;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   aw_cnt = 0;
    int   w_cnt = 0;
    int   aw0, w0;

    always #5 aclk = ~aclk;

    axi4l_if s0 ();
    axi4l_if s1 ();
    axi4l_if m ();
    axi4l_if f0 ();
    axi4l_if f1 ();
    axi4l_if fm ();

    axi4l_arbiter #(.FAIR(1'b1)) dut (.aclk(aclk), .aresetn(aresetn), .s0(s0), .s1(s1), .m(m));
    axi4l_arbiter #(.FAIR(1'b0)) dut_fixed (.aclk(aclk), .aresetn(aresetn), .s0(f0), .s1(f1), .m(fm));

    // Count handshakes seen by the peripheral
    always @(posedge aclk) begin
        if (m.awvalid && m.awready) aw_cnt <= aw_cnt + 1;
        if (m.wvalid && m.wready) w_cnt <= w_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge aclk);
        #2;
    endtask

    task automatic drive_w(input int who, input logic v, input logic [31:0] addr, input logic [31:0] data);
        if (who == 0) begin
            s0.awvalid = v; s0.wvalid = v; s0.awaddr = addr; s0.wdata = data; s0.wstrb = 4'hF;
        end else begin
            s1.awvalid = v; s1.wvalid = v; s1.awaddr = addr; s1.wdata = data; s1.wstrb = 4'hF;
        end
    endtask

    task automatic clear_all;
        s0.awaddr = 0; s0.awprot = 0; s0.awvalid = 0; s0.wdata = 0; s0.wstrb = 0; s0.wvalid = 0;
        s0.bready = 0; s0.araddr = 0; s0.arprot = 0; s0.arvalid = 0; s0.rready = 0;
        s1.awaddr = 0; s1.awprot = 0; s1.awvalid = 0; s1.wdata = 0; s1.wstrb = 0; s1.wvalid = 0;
        s1.bready = 0; s1.araddr = 0; s1.arprot = 0; s1.arvalid = 0; s1.rready = 0;
        f0.awaddr = 0; f0.awprot = 0; f0.awvalid = 0; f0.wdata = 0; f0.wstrb = 0; f0.wvalid = 0;
        f0.bready = 0; f0.araddr = 0; f0.arprot = 0; f0.arvalid = 0; f0.rready = 0;
        f1.awaddr = 0; f1.awprot = 0; f1.awvalid = 0; f1.wdata = 0; f1.wstrb = 0; f1.wvalid = 0;
        f1.bready = 0; f1.araddr = 0; f1.arprot = 0; f1.arvalid = 0; f1.rready = 0;
        m.awready = 0; m.wready = 0; m.bresp = 0; m.bvalid = 0;
        m.arready = 0; m.rdata = 0; m.rresp = 0; m.rvalid = 0;
        fm.awready = 0; fm.wready = 0; fm.bresp = 0; fm.bvalid = 0;
        fm.arready = 0; fm.rdata = 0; fm.rresp = 0; fm.rvalid = 0;
    endtask

    // Both masters write at once; peripheral always ready with B pending
    task automatic collide(input int first, input logic [31:0] a0, input logic [31:0] a1);
        drive_w(0, 1'b1, a0, ~a0);
        drive_w(1, 1'b1, a1, ~a1);
        s0.bready = 1; s1.bready = 1;
        m.awready = 1; m.wready = 1; m.bvalid = 1; m.bresp = 2'b00;
        #1 chk("col_idle_awvalid", m.awvalid, 0);
        cyc;
        #1 chk("col_win_awaddr", m.awaddr, first ? a1 : a0);
        chk("col_win_wdata", m.wdata, first ? ~a1 : ~a0);
        chk("col_win_awready", first ? s1.awready : s0.awready, 1);
        chk("col_lose_awready", first ? s0.awready : s1.awready, 0);
        cyc;
        drive_w(first, 1'b0, 0, 0);
        #1 chk("col_win_bvalid", first ? s1.bvalid : s0.bvalid, 1);
        chk("col_lose_bvalid", first ? s0.bvalid : s1.bvalid, 0);
        cyc;
        #1 chk("col_gap_awvalid", m.awvalid, 0);
        cyc;
        #1 chk("col_lose_awaddr", m.awaddr, first ? a0 : a1);
        chk("col_lose_awready_now", first ? s0.awready : s1.awready, 1);
        cyc;
        drive_w(1 - first, 1'b0, 0, 0);
        #1 chk("col_lose_bvalid_now", first ? s0.bvalid : s1.bvalid, 1);
        cyc;
        m.bvalid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clear_all();
        // Reset: requests and peripheral readies present, all handshakes must stay low
        s0.awvalid = 1; s0.wvalid = 1; s0.arvalid = 1; s0.bready = 1; s0.rready = 1;
        m.awready = 1; m.wready = 1; m.arready = 1; m.bvalid = 1; m.rvalid = 1;
        cyc; cyc;
        chk("rst_m_awvalid", m.awvalid, 0);
        chk("rst_m_wvalid", m.wvalid, 0);
        chk("rst_m_bready", m.bready, 0);
        chk("rst_m_arvalid", m.arvalid, 0);
        chk("rst_m_rready", m.rready, 0);
        chk("rst_s0_ready", {s0.awready, s0.wready, s0.arready}, 0);
        chk("rst_s0_valid", {s0.bvalid, s0.rvalid}, 0);
        chk("rst_s1_all", {s1.awready, s1.wready, s1.arready, s1.bvalid, s1.rvalid}, 0);
        clear_all();
        aresetn = 1;
        cyc;

        // Simultaneous writes after reset: s0 first, then s1
        collide(0, 32'h100, 32'h104);

        // s1 presents W first, AW three cycles later, peripheral stalls AW
        s1.wvalid = 1; s1.wdata = 32'hCAFE0001; s1.wstrb = 4'hF; s1.bready = 1;
        m.awready = 0; m.wready = 1; m.bvalid = 0;
        aw0 = aw_cnt; w0 = w_cnt;
        cyc;
        #1 chk("wfirst_m_wvalid", m.wvalid, 1);
        chk("wfirst_m_wdata", m.wdata, 32'hCAFE0001);
        chk("wfirst_s1_wready", s1.wready, 1);
        chk("wfirst_s0_wready", s0.wready, 0);
        chk("wfirst_m_awvalid", m.awvalid, 0);
        cyc;
        s1.wvalid = 0;
        #1 chk("wfirst_wdone", m.wvalid, 0);
        cyc;
        s1.awvalid = 1; s1.awaddr = 32'h0;
        #1 chk("wfirst_aw_fwd", m.awvalid, 1);
        chk("wfirst_aw_stall", s1.awready, 0);
        cyc;
        #1 chk("wfirst_aw_hold", m.awvalid, 1);
        cyc;
        m.awready = 1;
        #1 chk("wfirst_awready", s1.awready, 1);
        cyc;
        s1.awvalid = 0; m.bvalid = 1;
        #1 chk("wfirst_s1_bvalid", s1.bvalid, 1);
        chk("wfirst_s0_bvalid", s0.bvalid, 0);
        cyc;
        m.bvalid = 0;
        #1 chk("wfirst_aw_count", aw_cnt - aw0, 1);
        chk("wfirst_w_count", w_cnt - w0, 1);

        // Concurrent: s0 reads 0x004 while s1 writes 0x000
        s0.arvalid = 1; s0.araddr = 32'h4; s0.rready = 1;
        drive_w(1, 1'b1, 32'h0, 32'h12345678); s1.bready = 1;
        m.arready = 1; m.awready = 1; m.wready = 1;
        cyc;
        #1 chk("conc_m_arvalid", m.arvalid, 1);
        chk("conc_m_araddr", m.araddr, 32'h4);
        chk("conc_s0_arready", s0.arready, 1);
        chk("conc_s1_arready", s1.arready, 0);
        chk("conc_m_awaddr", m.awaddr, 32'h0);
        chk("conc_m_wdata", m.wdata, 32'h12345678);
        chk("conc_s1_awready", s1.awready, 1);
        chk("conc_s0_awready", s0.awready, 0);
        cyc;
        s0.arvalid = 0; drive_w(1, 1'b0, 0, 0);
        m.rvalid = 1; m.rdata = 32'hDEADBEEF; m.rresp = 2'b00; m.bvalid = 1; m.bresp = 2'b00;
        #1 chk("conc_s0_rvalid", s0.rvalid, 1);
        chk("conc_s0_rdata", s0.rdata, 32'hDEADBEEF);
        chk("conc_s1_rvalid", s1.rvalid, 0);
        chk("conc_s1_bvalid", s1.bvalid, 1);
        chk("conc_s0_bvalid", s0.bvalid, 0);
        chk("conc_m_rready", m.rready, 1);
        cyc;
        m.rvalid = 0; m.bvalid = 0;
        #1 chk("conc_done", {s0.rvalid, s1.bvalid}, 0);

        // B backpressure from s0 while s1 waits
        drive_w(0, 1'b1, 32'h8, 32'h88); s0.bready = 0;
        cyc;
        drive_w(1, 1'b1, 32'hC, 32'hCC);
        #1 chk("bp_grant_s0", m.awaddr, 32'h8);
        cyc;
        drive_w(0, 1'b0, 0, 0); m.bvalid = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_m_bready", m.bready, 0);
            chk("bp_s0_bvalid", s0.bvalid, 1);
            chk("bp_s1_awready", s1.awready, 0);
            chk("bp_m_awvalid", m.awvalid, 0);
            cyc;
        end
        s0.bready = 1;
        #1 chk("bp_release", m.bready, 1);
        cyc;
        #1 chk("bp_idle", m.awvalid, 0);
        cyc;
        #1 chk("bp_grant_s1", m.awaddr, 32'hC);
        chk("bp_s1_awready", s1.awready, 1);
        cyc;
        drive_w(1, 1'b0, 0, 0);
        #1 chk("bp_s1_b", s1.bvalid, 1);
        cyc;
        m.bvalid = 0;

        // Single write from s0
        drive_w(0, 1'b1, 32'h000, 32'hA5A5_0F0F);
        #1 chk("single_req_cycle", m.awvalid, 0);
        cyc;
        #1 chk("single_awaddr", m.awaddr, 32'h000);
        chk("single_wdata", m.wdata, 32'hA5A5_0F0F);
        chk("single_wstrb", m.wstrb, 4'hF);
        chk("single_valids", {m.awvalid, m.wvalid}, 2'b11);
        chk("single_s1_ready", {s1.awready, s1.wready}, 0);
        cyc;
        drive_w(0, 1'b0, 0, 0); m.bvalid = 1; m.bresp = 2'b00;
        #1 chk("single_s0_bvalid", s0.bvalid, 1);
        chk("single_s0_bresp", s0.bresp, 2'b00);
        chk("single_s1_bvalid", s1.bvalid, 0);
        cyc;
        m.bvalid = 0;
        #1 chk("single_done", s0.bvalid, 0);

        // Repeat collision after s0 was served last: s1 goes first
        collide(1, 32'h30, 32'h34);

        // Fixed priority instance: s0 keeps winning even back-to-back
        f0.awvalid = 1; f0.wvalid = 1; f0.awaddr = 32'h10; f0.wstrb = 4'hF; f0.bready = 1;
        f1.awvalid = 1; f1.wvalid = 1; f1.awaddr = 32'h14; f1.wstrb = 4'hF; f1.bready = 1;
        fm.awready = 1; fm.wready = 1; fm.bvalid = 1;
        cyc;
        #1 chk("fix_first", fm.awaddr, 32'h10);
        cyc;
        #1 chk("fix_f0_b", f0.bvalid, 1);
        cyc; cyc;
        #1 chk("fix_again_f0", fm.awaddr, 32'h10);
        chk("fix_f1_wait", f1.awready, 0);
        cyc;
        f0.awvalid = 0; f0.wvalid = 0;
        cyc; cyc;
        #1 chk("fix_then_f1", fm.awaddr, 32'h14);
        cyc;
        f1.awvalid = 0; f1.wvalid = 0;
        cyc;
        fm.bvalid = 0;

        // Reset asserted during W_ADDR_DATA
        drive_w(1, 1'b1, 32'h0, 32'h11);
        m.awready = 0; m.wready = 0; m.bvalid = 0;
        cyc;
        #1 chk("rstmid_pre", m.awvalid, 1);
        m.awready = 1; m.wready = 1;
        aresetn = 0;
        #1 chk("rstmid_m_valids", {m.awvalid, m.wvalid}, 0);
        chk("rstmid_s_ready", {s0.awready, s0.wready, s1.awready, s1.wready}, 0);
        drive_w(0, 1'b1, 32'h20, 32'h2);
        drive_w(1, 1'b1, 32'h24, 32'h3);
        cyc;
        aresetn = 1;
        #1 chk("rstmid_idle", m.awvalid, 0);
        cyc;
        #1 chk("rstmid_next_s0", m.awaddr, 32'h20);
        chk("rstmid_s0_awready", s0.awready, 1);
        chk("rstmid_s1_awready", s1.awready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
